// File: rtl/press_classifier.sv
// Press classifier: turns a clean level into short/long/repeat strobes, press width and press count.
// Optional auto-repeat strobe enabled by defining PRESS_CLASSIFIER_REPEAT_EN.
module press_classifier #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             hold,
  output logic [CNT_W-1:0] width,
  output logic             width_valid,
  output logic [7:0]       press_count
);
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_TICKS);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_sat, width_nx;
  logic [7:0]       pc_nx;
  logic             hold_nx, short_nx, long_nx, wv_nx;

  assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rcnt, rcnt_nx;
  logic          rep_nx;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    width_nx = width;
    pc_nx    = press_count;
    hold_nx  = hold;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    wv_nx    = 1'b0;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
    rcnt_nx  = rcnt;
    rep_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sig_in) begin
          state_nx = PRESS;
          cnt_nx   = CNT_W'(1);
          pc_nx    = press_count + 8'd1;
        end
      end
      PRESS: begin
        if (!sig_in) begin
          state_nx = IDLE;
          width_nx = cnt;
          wv_nx    = 1'b1;
          short_nx = 1'b1;
        end else if (cnt == LONG_M1) begin
          state_nx = HELD;
          cnt_nx   = LONG_CNT;
          long_nx  = 1'b1;
          hold_nx  = 1'b1;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
          rcnt_nx  = '0;
`endif
        end else begin
          cnt_nx = cnt_sat;
        end
      end
      HELD: begin
        if (sig_in) begin
          cnt_nx = cnt_sat;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
          // rcnt counts held samples since the last long/repeat strobe
          if (rcnt == RCNT_LAST) begin
            rcnt_nx = '0;
            rep_nx  = 1'b1;
          end else begin
            rcnt_nx = rcnt + 1'b1;
          end
`endif
        end else begin
          state_nx = IDLE;
          width_nx = cnt;
          wv_nx    = 1'b1;
          hold_nx  = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      width       <= '0;
      press_count <= '0;
      hold        <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      width_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      width       <= width_nx;
      press_count <= pc_nx;
      hold        <= hold_nx;
      short_pulse <= short_nx;
      long_pulse  <= long_nx;
      width_valid <= wv_nx;
    end
  end

`ifdef PRESS_CLASSIFIER_REPEAT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rcnt         <= rcnt_nx;
      repeat_pulse <= rep_nx;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: each press is reduced to its high-run length and the
// expected strobes (edge, kind, width, count) are queued; a negedge monitor pops and compares.
module tb_press_classifier;
  localparam int CW = 8, LT = 8, RT = 4;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clock = 1'b0, reset = 1'b1, sig_in = 1'b0;
  logic          short_pulse, long_pulse, repeat_pulse, hold, width_valid;
  logic [CW-1:0] width;
  logic [7:0]    press_count;

  press_classifier #(.CNT_W(CW), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
    .hold(hold), .width(width), .width_valid(width_valid), .press_count(press_count));

  typedef struct {int cyc; bit s; bit l; bit r; bit v; int w; int pc; bit h;} ev_t;
  ev_t q[$];
  ev_t e;
  int  cyc = 0, n_chk = 0, n_fail = 0, pc_m = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void push(int c, bit s, bit l, bit r, bit v, int w, bit h);
    ev_t x;
    x.cyc = c; x.s = s; x.l = l; x.r = r; x.v = v; x.w = w; x.pc = pc_m; x.h = h;
    q.push_back(x);
  endfunction

  // One press of L high samples followed by G low samples; called on a negedge.
  task automatic run(int L, int G);
    int s;
    s    = cyc + 1;
    pc_m = (pc_m + 1) % 256;
    if (L < LT) push(s + L, 1, 0, 0, 1, L, 0);
    else begin
      push(s + LT - 1, 0, 1, 0, 0, 0, 1);
      if (REP) for (int k = 1; LT + k * RT <= L; k++) push(s + LT - 1 + k * RT, 0, 0, 1, 0, 0, 1);
      push(s + L, 0, 0, 0, 1, (L > 255) ? 255 : L, 0);
    end
    sig_in = 1'b1;
    repeat (L) @(negedge clock);
    sig_in = 1'b0;
    repeat (G) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("missing_event_due_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (short_pulse || long_pulse || repeat_pulse || width_valid) begin
        if (q.size() == 0) check("unexpected_strobe_queue_size", 0, 1 + cyc);
        else begin
          e = q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("short_pulse", short_pulse, e.s);
          check("long_pulse", long_pulse, e.l);
          check("repeat_pulse", repeat_pulse, e.r);
          check("width_valid", width_valid, e.v);
          if (e.v) check("width", width, e.w);
          check("hold", hold, e.h);
          check("press_count", press_count, e.pc);
        end
      end
    end
  end

  initial begin
    int s;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {short_pulse, long_pulse, repeat_pulse, hold, width_valid, width, press_count}, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_outputs", {short_pulse, long_pulse, repeat_pulse, hold, width_valid, width, press_count}, 0);
    end

    run(5, 3);
    run(7, 2);
    run(8, 3);
    run(300, 2);
    run(20, 3);
    run(LT - 1, 1);
    run(LT, 1);
    for (int i = 0; i < 40; i++) run(int'($urandom_range(1, 24)), int'($urandom_range(1, 4)));
    for (int i = 0; i < 260; i++) run(1, 1);

    // Reset while in HELD: outputs clear at once, pending release is discarded
    s    = cyc + 1;
    pc_m = (pc_m + 1) % 256;
    push(s + LT - 1, 0, 1, 0, 0, 0, 1);
    sig_in = 1'b1;
    repeat (10) @(negedge clock);
    check("hold_before_reset", hold, 1);
    #2 reset = 1'b0;
    q.delete();
    pc_m = 0;
    #1;
    check("hold_after_reset", hold, 0);
    check("press_count_after_reset", press_count, 0);
    check("width_after_reset", width, 0);
    check("width_valid_after_reset", width_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    run(5, 3);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
